lcd_800_480_timing: RTL and testbench
=====================================

LCD_800_480_TIMING -- requirements
Module: lcd_800_480_timing

Interface
REQ-001 The block SHALL have parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 The block SHALL have parameter H_FRONT, default 40, horizontal front porch in clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 48, horizontal sync width in clocks.
REQ-004 The block SHALL have parameter H_BACK, default 40, horizontal back porch in clocks.
REQ-005 The block SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 The block SHALL have parameter V_FRONT, default 13, vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 3, vertical sync width in lines.
REQ-008 The block SHALL have parameter V_BACK, default 29, vertical back porch in lines.
REQ-009 The block SHALL have parameter SYNC_ACTIVE, default 0, asserted level of hsync and vsync.
REQ-010 The block SHALL have port clk, input, 1, the LCD pixel clock from the board PLL; the block SHALL use this one clock only.
REQ-011 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-012 The block SHALL have port hsync, output, 1, horizontal sync.
REQ-013 The block SHALL have port vsync, output, 1, vertical sync.
REQ-014 The block SHALL have port display_on, output, 1, data enable (active pixel).
REQ-015 The block SHALL have port x, output, 10, horizontal position.
REQ-016 The block SHALL have port y, output, 10, vertical position.
REQ-017 The block SHALL have port frame_start, output, 1, one-clock pulse at pixel (0,0).

Function
REQ-018 Internal h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = sum of H params, 928 default), wrapping to 0.
REQ-019 Internal v_cnt SHALL increment only on h_cnt wrap, range 0..V_TOTAL-1 (525 default); at h_cnt and v_cnt both at their maxima both SHALL wrap to 0 on the same edge.
REQ-020 Line phase order SHALL be active, front porch, sync, back porch; frame phase order likewise.
REQ-021 All outputs SHALL be registered, reflecting counter state with exactly one clock latency.
REQ-022 display_on SHALL be 1 iff h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-023 hsync SHALL equal SYNC_ACTIVE iff H_ACTIVE+H_FRONT <= h_cnt < H_ACTIVE+H_FRONT+H_SYNC (840..887 default), else its inverse.
REQ-024 vsync SHALL equal SYNC_ACTIVE for all clocks with V_ACTIVE+V_FRONT <= v_cnt < V_ACTIVE+V_FRONT+V_SYNC (lines 493..495 default), else its inverse.
REQ-025 x and y SHALL equal h_cnt and v_cnt, including during blanking.
REQ-026 frame_start SHALL be 1 for exactly the one clock where h_cnt=0 and v_cnt=0.
REQ-027 Counters SHALL never leave their ranges; any out-of-range value SHALL wrap to 0 on the next edge.

Reset
REQ-028 On rst, h_cnt, v_cnt, x, y SHALL be 0, display_on and frame_start 0, hsync and vsync at inactive level (~SYNC_ACTIVE), asynchronously.
REQ-029 On the first clk edge after rst deasserts, outputs SHALL show x=0, y=0, display_on=1, frame_start=1.
REQ-030 rst asserted mid-frame SHALL abort the frame; timing SHALL restart from (0,0) per REQ-029.

Configuration
REQ-031 With macro LCD_TIMING_FRAME_CNT_EN defined, the block SHALL add output frame_cnt, 8 bits, reset 0, incremented on the same edge frame_start goes to 1 after the first frame, wrapping 255->0.
REQ-032 Without LCD_TIMING_FRAME_CNT_EN, port frame_cnt and its logic SHALL be absent; all other behaviour unchanged.

Verification
REQ-033 Release rst -> first edge: x=0, y=0, display_on=1, frame_start=1, hsync=vsync=1 (default polarity).
REQ-034 Run one line -> display_on high 800 clocks, hsync low for 48 clocks starting at x=840, line period 928 clocks.
REQ-035 Run one frame -> frame_start period 487200 clocks, vsync low 2784 clocks (lines 493..495), display_on high 384000 clocks.
REQ-036 Assert rst at x=500, y=200 -> outputs at reset values immediately; after release frame restarts at (0,0).
REQ-037 Observe transition from x=927, y=524 -> next clock x=0, y=0, frame_start=1; x=927, y=10 -> x=0, y=11.
REQ-038 With LCD_TIMING_FRAME_CNT_EN, run 257 frames -> frame_cnt wraps 255->0 and reads 0 at start of frame 257.

Source files
------------

// File: rtl/lcd_800_480_timing.sv
// 800x480 LCD raster timing generator: free-running pixel/line counters with registered syncs, DE and position.
// Optional frame counter output is built only when LCD_TIMING_FRAME_CNT_EN is defined.
module lcd_800_480_timing #(
    parameter int   H_ACTIVE    = 800,
    parameter int   H_FRONT     = 40,
    parameter int   H_SYNC      = 48,
    parameter int   H_BACK      = 40,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FRONT     = 13,
    parameter int   V_SYNC      = 3,
    parameter int   V_BACK      = 29,
    parameter logic SYNC_ACTIVE = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] H_DE_END = 10'(H_ACTIVE);
    localparam logic [9:0] V_DE_END = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic [9:0] h_nxt;
    logic [9:0] v_nxt;
    logic       h_wrap;

    // >= rather than == so a corrupted counter falls back to 0 on the next edge
    always_comb begin
        h_wrap = (h_cnt >= H_LAST);
        h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
        v_nxt  = v_cnt;
        if (v_cnt > V_LAST) begin
            v_nxt = 10'd0;
        end else if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt       <= 10'd0;
            v_cnt       <= 10'd0;
            x           <= 10'd0;
            y           <= 10'd0;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
            hsync       <= ~SYNC_ACTIVE;
            vsync       <= ~SYNC_ACTIVE;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            x           <= h_cnt;
            y           <= v_cnt;
            display_on  <= (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
            frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            hsync       <= ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vsync       <= ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

`ifdef LCD_TIMING_FRAME_CNT_EN
    logic started;

    // The first frame after reset is frame 0; later frame starts advance the count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt <= 8'd0;
            started   <= 1'b0;
        end else if ((h_cnt == 10'd0) && (v_cnt == 10'd0)) begin
            started <= 1'b1;
            if (started) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_lcd_800_480_timing.sv
// Bench: default-parameter instance checked against a checkpoint table; a small-raster instance
// (active-high syncs) checked every clock against a scoreboard fed from a cycle-index model.
module tb_lcd_800_480_timing;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
    } obs_t;

    typedef struct {
        int   k;
        obs_t exp;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, rst_b;
    logic       hs_a, vs_a, de_a, fs_a, hs_b, vs_b, de_b, fs_b;
    logic [9:0] x_a, y_a, x_b, y_b;
`ifdef LCD_TIMING_FRAME_CNT_EN
    logic [7:0] fc_a, fc_b;
`endif

    lcd_800_480_timing dut_a (
        .clk(clk), .rst(rst_a), .hsync(hs_a), .vsync(vs_a), .display_on(de_a),
        .x(x_a), .y(y_a), .frame_start(fs_a)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_a)
`endif
    );

    lcd_800_480_timing #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_ACTIVE(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .SYNC_ACTIVE(1'b1)
    ) dut_b (
        .clk(clk), .rst(rst_b), .hsync(hs_b), .vsync(vs_b), .display_on(de_b),
        .x(x_b), .y(y_b), .frame_start(fs_b)
`ifdef LCD_TIMING_FRAME_CNT_EN
        , .frame_cnt(fc_b)
`endif
    );

    obs_t obs_a, obs_b;
    assign obs_a = {x_a, y_a, de_a, hs_a, vs_a, fs_a};
    assign obs_b = {x_b, y_b, de_b, hs_b, vs_b, fs_b};

    int   total = 0;
    int   bad   = 0;
    obs_t sb_q[$];
    row_t tbl[11];

    task automatic check(input string name, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got x=%0d y=%0d de=%b hs=%b vs=%b fs=%b, want x=%0d y=%0d de=%b hs=%b vs=%b fs=%b",
                     name, got.x, got.y, got.de, got.hs, got.vs, got.fs,
                     exp.x, exp.y, exp.de, exp.hs, exp.vs, exp.fs);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    // Small raster: 15 clocks/line (8 active, 2 front, 3 sync, 2 back), 10 lines/frame (6,1,2,1)
    function automatic obs_t model_b(input int n);
        obs_t o;
        int h, v;
        h    = n % 15;
        v    = (n / 15) % 10;
        o.x  = 10'(h);
        o.y  = 10'(v);
        o.de = (h < 8) && (v < 6);
        o.hs = (h >= 10) && (h < 13);
        o.vs = (v >= 7) && (v < 9);
        o.fs = (h == 0) && (v == 0);
        return o;
    endfunction

    int n_b;

    // One edge of dut_b: predict the state being registered, then compare once outputs settle
    task automatic step_b(input string name);
        obs_t e;
        @(posedge clk);
        sb_q.push_back(model_b(n_b));
        n_b++;
        #1;
        if (sb_q.size() == 0) begin
            check_int({name, "_queue_empty"}, 0, 1);
        end else begin
            e = sb_q.pop_front();
            check(name, obs_b, e);
        end
    endtask

    initial begin
        int   k, row, de_cnt, hs_cnt, hs_first;
        int   de_f, hs_f, vs_f, fs_edges[$];

        tbl[0]  = '{1,     '{10'd0,   10'd0,  1'b1, 1'b1, 1'b1, 1'b1}};
        tbl[1]  = '{800,   '{10'd799, 10'd0,  1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[2]  = '{801,   '{10'd800, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[3]  = '{841,   '{10'd840, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[4]  = '{888,   '{10'd887, 10'd0,  1'b0, 1'b0, 1'b1, 1'b0}};
        tbl[5]  = '{889,   '{10'd888, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[6]  = '{928,   '{10'd927, 10'd0,  1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[7]  = '{929,   '{10'd0,   10'd1,  1'b1, 1'b1, 1'b1, 1'b0}};
        tbl[8]  = '{9280,  '{10'd927, 10'd9,  1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[9]  = '{10208, '{10'd927, 10'd10, 1'b0, 1'b1, 1'b1, 1'b0}};
        tbl[10] = '{10209, '{10'd0,   10'd11, 1'b1, 1'b1, 1'b1, 1'b0}};

        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_a", obs_a, '{10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0});
        check("reset_b", obs_b, '{10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0});

        // Default raster: walk the checkpoint table, gathering first-line statistics on the way
        rst_a    = 1'b0;
        k        = 0;
        row      = 0;
        de_cnt   = 0;
        hs_cnt   = 0;
        hs_first = -1;
        while (row < 11) begin
            @(posedge clk);
            #1;
            k++;
            if (k <= 928) begin
                if (de_a) de_cnt++;
                if (!hs_a) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = int'(x_a);
                end
            end
            if (k == tbl[row].k) begin
                check($sformatf("table_row%0d_k%0d", row, k), obs_a, tbl[row].exp);
                row++;
            end
        end
        check_int("line_de_clocks", de_cnt, 800);
        check_int("line_hsync_clocks", hs_cnt, 48);
        check_int("line_hsync_first_x", hs_first, 840);

        // Small raster: scoreboard every clock across two full frames plus a bit
        @(negedge clk);
        rst_b = 1'b0;
        n_b   = 0;
        de_f  = 0;
        hs_f  = 0;
        vs_f  = 0;
        for (int i = 0; i < 351; i++) begin
            step_b("sb_run");
            if (i < 150) begin
                if (de_b) de_f++;
                if (hs_b) hs_f++;
                if (vs_b) vs_f++;
            end
            if (fs_b) fs_edges.push_back(i);
        end
        check_int("frame_de_clocks", de_f, 48);
        check_int("frame_hsync_clocks", hs_f, 30);
        check_int("frame_vsync_clocks", vs_f, 30);
        check_int("frame_start_pulses", fs_edges.size(), 3);
        if (fs_edges.size() >= 3) begin
            check_int("frame_period_1", fs_edges[1] - fs_edges[0], 150);
            check_int("frame_period_2", fs_edges[2] - fs_edges[1], 150);
        end
        check("pre_abort_pos", obs_b, '{10'd5, 10'd3, 1'b1, 1'b0, 1'b0, 1'b0});

        // Mid-frame abort: reset must take effect without a clock, then restart at (0,0)
        @(negedge clk);
        rst_b = 1'b1;
        #1;
        check("abort_async", obs_b, '{10'd0, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst_b = 1'b0;
        n_b   = 0;
        sb_q.delete();
        for (int i = 0; i < 20; i++) begin
            step_b("sb_restart");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
